fnd_scan_controller: RTL and testbench

//  Drives a 4-digit FND from a binary count. Converts a loaded 14-bit binary value
//  (0..9999) to packed BCD with a sequential double-dabble core, then time-multiplexes
//  the four digits. Outputs feed the FND digit/font decoder's digit-select, value and

---
 rtl/fnd_pkg.sv | 25 ++
 rtl/fnd_scan_controller_if.sv | 23 ++
 rtl/fnd_scan_controller_bin2bcd_seq.sv | 61 ++++++
 rtl/fnd_scan_controller.sv | 88 ++++++++
 tb/tb_fnd_scan_controller.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit FND scan controller.
package fnd_pkg;

  localparam int unsigned FND_DIGITS = 4;
  localparam int unsigned BIN_W      = 14;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned FND_MAX    = 9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_e;

  // Double-dabble pre-shift correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < int'(FND_DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Value/load/enable inputs and digit-drive outputs of the FND scan controller.
interface fnd_scan_controller_if;
  import fnd_pkg::*;

  logic [BIN_W-1:0] i_value;
  logic             i_load;
  logic             i_En;
  logic [1:0]       o_DigitSelect;
  logic [3:0]       o_value;
  logic             o_En;
  logic             o_busy;
  logic             o_ovf;

  modport master (
    output i_value, i_load, i_En,
    input  o_DigitSelect, o_value, o_En, o_busy, o_ovf
  );

  modport slave (
    input  i_value, i_load, i_En,
    output o_DigitSelect, o_value, o_En, o_busy, o_ovf
  );
endinterface

// File: rtl/fnd_scan_controller_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, 14 shift cycles then one
// COMMIT cycle during which done is high and bcd holds the final result.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       cnt_q;
  logic [BCD_W-1:0] bcd_adj;

  assign bcd_adj = dabble_adjust(bcd_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'(BIN_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath: capture on start, then adjust-and-shift once per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == COMMIT);
  assign bcd  = bcd_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: clamps and converts a binary value to BCD, holds it in
// a display register and time-multiplexes the digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the most
// significant non-zero digit; digit 0 always shown).
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  fnd_scan_controller_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic             core_busy, core_done, accept;
  logic [BCD_W-1:0] core_bcd;
  logic [BIN_W-1:0] clamped;
  logic [BCD_W-1:0] display_q;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       value_q;
  logic             en_q, ovf_q, digit_lit;

  assign accept  = bus.i_load & ~core_busy;
  assign clamped = (bus.i_value > BIN_W'(FND_MAX)) ? BIN_W'(FND_MAX) : bus.i_value;

  bin2bcd_seq u_bin2bcd (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .start (accept),
    .bin   (clamped),
    .busy  (core_busy),
    .done  (core_done),
    .bcd   (core_bcd)
  );

  // Overflow flag and display register; display only changes on COMMIT.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ovf_q     <= 1'b0;
      display_q <= '0;
    end else begin
      if (accept)    ovf_q     <= (bus.i_value > BIN_W'(FND_MAX));
      if (core_done) display_q <= core_bcd;
    end
  end

  // Free-running prescaler and digit counter next state.
  always_comb begin
    presc_d = presc_q + DIV_W'(1);
    digit_d = digit_q;
    if (presc_q == DIV_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Lit if this is digit 0 or any nibble at or above it is non-zero.
  assign digit_lit = (digit_d == 2'd0) || (|(display_q >> {digit_d, 2'b00}));
`else
  assign digit_lit = 1'b1;
`endif

  // Scan registers; value and enable use digit_d so they line up with o_DigitSelect.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      digit_q <= '0;
      value_q <= '0;
      en_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      value_q <= display_q[{digit_d, 2'b00} +: 4];
      en_q    <= bus.i_En & digit_lit;
    end
  end

  assign bus.o_DigitSelect = digit_q;
  assign bus.o_value       = value_q;
  assign bus.o_En          = en_q;
  assign bus.o_busy        = core_busy;
  assign bus.o_ovf         = ovf_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller with SCAN_DIV=4.
module tb_fnd_scan_controller;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fnd_scan_controller_if bus ();

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: edges since reset release, shown number, pending conversion.
  int k, disp, pending, commit_edge, busy_end;
  bit ovf;

  typedef struct {
    int          value;
    logic [15:0] exp_bcd;
    bit          exp_ovf;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec_digit(input int v, input int d);
    int r = v;
    for (int i = 0; i < d; i++) r = r / 10;
    return r % 10;
  endfunction

  function automatic bit lit(input int v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return (d == 0) || (v >= p);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    k = 0; disp = 0; pending = 0; commit_edge = -1; busy_end = 0; ovf = 0;
  endtask

  // One clock: drive inputs, advance model across the edge, compare all outputs.
  task automatic step(input bit ld, input int val, input bit en);
    int edig, evalue;
    bit een, ebusy;
    bus.i_load  = ld;
    bus.i_value = val[13:0];
    bus.i_En    = en;
    @(posedge clk);
    k++;
    edig   = (k / SCAN_DIV) % 4;
    evalue = dec_digit(disp, edig);
    een    = en && lit(disp, edig);
    if (k == commit_edge) disp = pending;
    if (ld && !((k - 1) < busy_end)) begin
      ovf         = (val > 9999);
      pending     = (val > 9999) ? 9999 : val;
      commit_edge = k + 15;
      busy_end    = k + 15;
    end
    ebusy = (k < busy_end);
    #1;
    check("digit_select", int'(bus.o_DigitSelect), edig);
    check("value", int'(bus.o_value), evalue);
    check("en", int'(bus.o_En), int'(een));
    check("busy", int'(bus.o_busy), int'(ebusy));
    check("ovf", int'(bus.o_ovf), int'(ovf));
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1'b0, 0, en);
  endtask

  // Observe one full scan (16 cycles) and assemble the shown BCD word.
  task automatic collect(output logic [15:0] obs);
    obs = '0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 0, 1'b1);
      obs[4*bus.o_DigitSelect +: 4] = bus.o_value;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit"}, int'(bus.o_DigitSelect), 0);
    check({tag, "_value"}, int'(bus.o_value), 0);
    check({tag, "_en"}, int'(bus.o_En), 0);
    check({tag, "_busy"}, int'(bus.o_busy), 0);
    check({tag, "_ovf"}, int'(bus.o_ovf), 0);
  endtask

  logic [15:0] obs;

  initial begin
    tbl[0] = '{1234,  16'h1234, 1'b0};
    tbl[1] = '{12000, 16'h9999, 1'b1};
    tbl[2] = '{5,     16'h0005, 1'b0};
    tbl[3] = '{9999,  16'h9999, 1'b0};
    tbl[4] = '{10000, 16'h9999, 1'b1};
    tbl[5] = '{0,     16'h0000, 1'b0};
    tbl[6] = '{42,    16'h0042, 1'b0};
    tbl[7] = '{16383, 16'h9999, 1'b1};

    bus.i_load = 1'b0; bus.i_value = '0; bus.i_En = 1'b0;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan with display disabled.
    idle(20, 1'b0);

    // Table of loads: full latency, then one whole scan of the committed value.
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].value, 1'b1);
      idle(15, 1'b1);
      collect(obs);
      check("tbl_display", int'(obs), int'(tbl[i].exp_bcd));
      check("tbl_ovf", int'(bus.o_ovf), int'(tbl[i].exp_ovf));
    end

    // Display enable off: every digit disabled.
    idle(8, 1'b0);

    // Load while busy is dropped; a load after busy falls is accepted.
    step(1'b1, 1234, 1'b1);
    idle(4, 1'b1);
    step(1'b1, 777, 1'b1);
    idle(10, 1'b1);
    collect(obs);
    check("drop_display", int'(obs), 16'h1234);
    step(1'b1, 777, 1'b1);
    idle(15, 1'b1);
    collect(obs);
    check("reload_display", int'(obs), 16'h0777);

    // Reset in the middle of a conversion.
    step(1'b1, 12000, 1'b1);
    idle(15, 1'b1);
    step(1'b1, 8888, 1'b1);
    idle(6, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    collect(obs);
    check("post_reset_display", int'(obs), 0);

    // Randomised traffic against the reference model.
    begin
      bit en = 1'b1;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 9) == 0) en = ~en;
        step($urandom_range(0, 7) == 0, int'($urandom_range(0, 16383)), en);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
